// File: rtl/hello_pkg.sv
// rtl/hello_pkg.sv - letter codes, FSM states and code helpers for hello_detector
package hello_pkg;

    typedef enum logic [2:0] {
        CODE_H     = 3'd0,
        CODE_E     = 3'd1,
        CODE_L     = 3'd2,
        CODE_O     = 3'd3,
        CODE_BLANK = 3'd4
    } letter_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_H    = 3'd1,
        GOT_HE   = 3'd2,
        GOT_HEL  = 3'd3,
        GOT_HELL = 3'd4
    } state_t;

    // Codes above BLANK have no letter and break any sequence in progress.
    function automatic logic is_legal(input logic [2:0] code);
        return (code <= CODE_BLANK);
    endfunction

    function automatic state_t restart_state(input logic [2:0] code);
        return (code == CODE_H) ? GOT_H : IDLE;
    endfunction

endpackage

// File: rtl/hello_detector_if.sv
// rtl/hello_detector_if.sv - letter-code input channel from the upstream code register
interface hello_detector_if;
    logic [2:0] Code;
    logic       Valid;

    modport master (output Code, output Valid);
    modport slave  (input  Code, input  Valid);
endinterface

// File: rtl/hello_sat_counter.sv
// rtl/hello_sat_counter.sv - saturating up-counter of detections
module hello_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             Inc,
    output logic [CNT_W-1:0] Count
);

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            Count <= '0;
        end else if (Inc && (Count != {CNT_W{1'b1}})) begin
            Count <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/hello_detector.sv
// rtl/hello_detector.sv - H-E-L-L-O sequence detector; HELLO_DET_COUNT_EN adds a detection counter
module hello_detector
    import hello_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               Clk,
    input  logic               ClrN,
    hello_detector_if.slave    in_if,
    output logic               Found,
    output logic [2:0]         State,
    output logic [CNT_W-1:0]   Count
);

    state_t state_q, state_d;
    logic   found_q, found_d;

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q <= IDLE;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            found_q <= found_d;
        end
    end

    // Any unexpected legal letter restarts matching, so an H mid-sequence lands in GOT_H.
    always_comb begin
        state_d = state_q;
        found_d = 1'b0;
        if (in_if.Valid) begin
            if (!is_legal(in_if.Code)) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE:     state_d = restart_state(in_if.Code);
                    GOT_H:    state_d = (in_if.Code == CODE_E) ? GOT_HE   : restart_state(in_if.Code);
                    GOT_HE:   state_d = (in_if.Code == CODE_L) ? GOT_HEL  : restart_state(in_if.Code);
                    GOT_HEL:  state_d = (in_if.Code == CODE_L) ? GOT_HELL : restart_state(in_if.Code);
                    GOT_HELL: begin
                        if (in_if.Code == CODE_O) begin
                            state_d = IDLE;
                            found_d = 1'b1;
                        end else begin
                            state_d = restart_state(in_if.Code);
                        end
                    end
                    default:  state_d = IDLE;
                endcase
            end
        end
    end

    assign Found = found_q;
    assign State = state_q;

`ifdef HELLO_DET_COUNT_EN
    // Counts on the accepting edge so Count steps together with the Found pulse.
    hello_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .Clk   (Clk),
        .ClrN  (ClrN),
        .Inc   (found_d),
        .Count (Count)
    );
`else
    assign Count = '0;
`endif

endmodule

// File: tb/tb_hello_detector.sv
// tb/tb_hello_detector.sv - self-checking bench for hello_detector (vectors, corner sequences, random vs model)
module tb_hello_detector;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             ClrN;
    logic             Found;
    logic [2:0]       State;
    logic [CNT_W-1:0] Count;

    hello_detector_if bus ();

    hello_detector #(.CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .ClrN  (ClrN),
        .in_if (bus),
        .Found (Found),
        .State (State),
        .Count (Count)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: accepted letters since the last break, matched against the word.
    logic [2:0] pat [5];
    logic [2:0] hist [$];
    int         m_state;
    bit         m_found;
    int         m_cnt;

    typedef struct {
        bit         v;
        logic [2:0] c;
        logic [2:0] st;
        bit         f;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int match_len();
        int best = 0;
        for (int k = 1; k <= 4; k++) begin
            bit ok = (hist.size() >= k);
            for (int j = 0; ok && j < k; j++)
                if (hist[hist.size() - k + j] != pat[j]) ok = 0;
            if (ok) best = k;
        end
        return best;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0;
        m_found = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input bit v, input logic [2:0] c);
        m_found = 0;
        if (v) begin
            if (c > 3'd4) begin
                hist.delete();
            end else begin
                bit hit = 1;
                hist.push_back(c);
                if (hist.size() > 5) void'(hist.pop_front());
                if (hist.size() != 5) hit = 0;
                for (int j = 0; hit && j < 5; j++)
                    if (hist[j] != pat[j]) hit = 0;
                if (hit) begin
                    m_found = 1;
                    hist.delete();
`ifdef HELLO_DET_COUNT_EN
                    if (m_cnt < CNT_MAX) m_cnt++;
`endif
                end
            end
        end
        m_state = match_len();
    endtask

    task automatic step(input bit v, input logic [2:0] c);
        @(negedge Clk);
        bus.Valid = v;
        bus.Code  = c;
        @(posedge Clk);
        #1;
        model_step(v, c);
        check("model_state", int'(State), m_state);
        check("model_found", int'(Found), int'(m_found));
        check("model_count", int'(Count), m_cnt);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        ClrN      = 1'b0;
        bus.Valid = 1'b0;
        #1;
        model_reset();
        check("reset_state", int'(State), 0);
        check("reset_found", int'(Found), 0);
        check("reset_count", int'(Count), 0);
        @(negedge Clk);
        ClrN = 1'b1;
    endtask

    task automatic push(input bit v, input logic [2:0] c, input logic [2:0] st, input bit f);
        vec_t t;
        t.v = v; t.c = c; t.st = st; t.f = f;
        tbl.push_back(t);
    endtask

    initial begin
        pat[0] = 3'd0; pat[1] = 3'd1; pat[2] = 3'd2; pat[3] = 3'd2; pat[4] = 3'd3;
        ClrN      = 1'b0;
        bus.Valid = 1'b0;
        bus.Code  = 3'd0;
        model_reset();
        #2;
        check("reset_state_init", int'(State), 0);
        check("reset_found_init", int'(Found), 0);
        check("reset_count_init", int'(Count), 0);
        do_reset();

        // H E L L O, then an idle edge
        push(1, 0, 1, 0); push(1, 1, 2, 0); push(1, 2, 3, 0); push(1, 2, 4, 0);
        push(1, 3, 0, 1); push(0, 3, 0, 0);
        // H E L H E L L O: overlapping H restarts at GOT_H
        push(1, 0, 1, 0); push(1, 1, 2, 0); push(1, 2, 3, 0); push(1, 0, 1, 0);
        push(1, 1, 2, 0); push(1, 2, 3, 0); push(1, 2, 4, 0); push(1, 3, 0, 1);
        push(0, 0, 0, 0);
        // H E 7 L L O: illegal code kills the sequence
        push(1, 0, 1, 0); push(1, 1, 2, 0); push(1, 7, 0, 0); push(1, 2, 0, 0);
        push(1, 2, 0, 0); push(1, 3, 0, 0);
        // H H BLANK, then back-to-back HELLO HELLO
        push(1, 0, 1, 0); push(1, 0, 1, 0); push(1, 4, 0, 0);
        for (int r = 0; r < 2; r++) begin
            push(1, 0, 1, 0); push(1, 1, 2, 0); push(1, 2, 3, 0); push(1, 2, 4, 0);
            push(1, 3, 0, 1);
        end
        push(1, 5, 0, 0); push(1, 6, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].c);
            check($sformatf("vec%0d_state", i), int'(State), int'(tbl[i].st));
            check($sformatf("vec%0d_found", i), int'(Found), int'(tbl[i].f));
        end

        // Valid gaps while in GOT_HELL hold the state
        do_reset();
        step(1, 0); step(1, 1); step(1, 2); step(1, 2);
        for (int i = 0; i < 3; i++) begin
            step(0, 3'(i));
            check("gap_state", int'(State), 4);
            check("gap_found", int'(Found), 0);
        end
        step(1, 3);
        check("gap_final_found", int'(Found), 1);
        step(0, 0);
        check("gap_found_one_cycle", int'(Found), 0);

        // Asynchronous reset between clocks discards progress
        step(1, 0); step(1, 1); step(1, 2); step(1, 2);
        @(negedge Clk);
        #2;
        ClrN = 1'b0;
        #1;
        model_reset();
        check("midreset_state", int'(State), 0);
        check("midreset_found", int'(Found), 0);
        #1;
        ClrN = 1'b1;
        step(1, 3);
        check("midreset_no_found", int'(Found), 0);
        check("midreset_after_state", int'(State), 0);

        // Five complete words: counter saturates at CNT_MAX
        do_reset();
        for (int n = 0; n < 5; n++) begin
            step(1, 0); step(1, 1); step(1, 2); step(1, 2); step(1, 3);
            check("sat_found", int'(Found), 1);
`ifdef HELLO_DET_COUNT_EN
            check("sat_count", int'(Count), (n + 1 < CNT_MAX) ? n + 1 : CNT_MAX);
`else
            check("sat_count", int'(Count), 0);
`endif
        end

        // Random traffic biased toward the next needed letter
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            bit v = (r < 85);
            logic [2:0] c = (r < 60) ? pat[m_state] : 3'($urandom_range(0, 7));
            step(v, c);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
